// File: rtl/agc_mem_sequencer.sv
// ---------------------------------------------------------------------------
// agc_mem_sequencer
//   Single-word access sequencer in front of the AGC erasable/fixed data
//   memory. Walks each CPU request through IDLE -> SETUP -> (READ | EDIT ->
//   STROBE) -> DONE. It captures read data, applies CYR/SR/CYL/EDOP editing
//   to writes, rejects writes to fixed memory and suppresses writes to the
//   hard-wired zero register.
//
//   Build option: define MEM_EDIT_EN to enable the editing transforms. When it
//   is undefined, writes pass through unchanged. The EDIT state is still
//   visited, so write timing is identical in both builds.
// ---------------------------------------------------------------------------
module agc_mem_sequencer #(
  parameter logic [11:0] ZERO_ADDR = 12'o0007,
  parameter logic [11:0] EDIT_BASE = 12'o0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [14:0] wdata,
  output logic        ack,
  output logic        busy,
  output logic [14:0] rdata,
  output logic        err,
  output logic [11:0] mem_addr,
  output logic [14:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_tp,
  input  logic [14:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_READ,
    S_EDIT,
    S_STROBE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic [14:0] w_edit_data;
  logic        w_is_fixed;
  logic        w_is_zero;

`ifdef MEM_EDIT_EN
  // Editing-register transform, evaluated on the incoming request so that
  // mem_wdata is already final and stable from SETUP onwards.
  always_comb begin
    // NOTE: default first so every path assigns w_edit_data (no latch).
    w_edit_data = wdata;
    if (addr == EDIT_BASE)                    w_edit_data = {wdata[0], wdata[14:1]};   // CYR
    else if (addr == EDIT_BASE + 12'd1)       w_edit_data = {wdata[14], wdata[14:1]};  // SR
    else if (addr == EDIT_BASE + 12'd2)       w_edit_data = {wdata[13:0], wdata[14]};  // CYL
    else if (addr == EDIT_BASE + 12'd3)       w_edit_data = {7'd0, wdata[14:7]};       // EDOP
  end
`else
  assign w_edit_data = wdata;
`endif

  // Address classification works on the latched address, not the live input.
  assign w_is_fixed = (mem_addr[11:10] != 2'b00);
  assign w_is_zero  = (mem_addr == ZERO_ADDR);

  // Sequencer FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_tp    <= 1'b0;
    end else begin
      // NOTE: ack and mem_tp are single-cycle pulses. Default them low here
      // and raise them only on the transition that enters their state.
      ack    <= 1'b0;
      mem_tp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state  <= S_SETUP;
            busy     <= 1'b1;
            err      <= 1'b0;
            r_we     <= we;
            mem_addr <= addr;
            if (we) mem_wdata <= w_edit_data;
          end
        end
        S_SETUP: begin
          if (!r_we) begin
            r_state <= S_READ;
          end else if (w_is_fixed) begin
            r_state <= S_DONE;
            err     <= 1'b1;
            ack     <= 1'b1;
          end else if (w_is_zero) begin
            r_state <= S_DONE;
            ack     <= 1'b1;
          end else begin
            r_state <= S_EDIT;
            mem_we  <= 1'b1;
          end
        end
        S_READ: begin
          rdata   <= w_is_zero ? 15'd0 : mem_rdata;
          r_state <= S_DONE;
          ack     <= 1'b1;
        end
        S_EDIT: begin
          // mem_we has been high for a full cycle before the strobe rises.
          r_state <= S_STROBE;
          mem_tp  <= 1'b1;
        end
        S_STROBE: begin
          r_state <= S_DONE;
          mem_we  <= 1'b0;
          ack     <= 1'b1;
        end
        S_DONE: begin
          // A request seen here is deliberately ignored. It is accepted in
          // the following IDLE cycle if the requester still holds it.
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_agc_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_agc_mem_sequencer
//   Self-checking bench for agc_mem_sequencer. A behavioural data memory
//   answers the DUT. A reference memory image, together with per-access
//   expectations computed from the access rules, predicts latency, err,
//   rdata, strobe count and edited write data. Honours MEM_EDIT_EN.
// ---------------------------------------------------------------------------
module tb_agc_mem_sequencer;

  localparam logic [11:0] ZERO_ADDR = 12'o0007;
  localparam logic [11:0] EDIT_BASE = 12'o0020;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [11:0] addr  = '0;
  logic [14:0] wdata = '0;
  logic        ack, busy, err, mem_we, mem_tp;
  logic [14:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  always #5 clk = ~clk;

  agc_mem_sequencer #(.ZERO_ADDR(ZERO_ADDR), .EDIT_BASE(EDIT_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .busy(busy), .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_tp(mem_tp), .mem_rdata(mem_rdata)
  );

  // Behavioural data memory: combinational read, write on the rising edge of mem_tp.
  logic [14:0] mem     [0:4095];
  logic [14:0] ref_mem [0:4095];
  int          tp_edges = 0;
  int          tp_no_we = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge mem_tp) begin
    tp_edges++;
    if (mem_we) mem[mem_addr] = mem_wdata;
    else        tp_no_we++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Editing rules expressed arithmetically on the integer value of the word.
  function automatic logic [14:0] edit_model(input logic [11:0] a, input logic [14:0] w);
    int v;
    int r;
    bit edit_on;
`ifdef MEM_EDIT_EN
    edit_on = 1'b1;
`else
    edit_on = 1'b0;
`endif
    v = int'(w);
    r = v;
    if (edit_on && a == EDIT_BASE)           r = (v >> 1) | ((v & 1) << 14);
    else if (edit_on && a == EDIT_BASE + 1)  r = (v >> 1) | (v & 'h4000);
    else if (edit_on && a == EDIT_BASE + 2)  r = ((v << 1) & 'h7fff) | (v >> 14);
    else if (edit_on && a == EDIT_BASE + 3)  r = v >> 7;
    return r[14:0];
  endfunction

  bit          pending_done = 1'b0;  // last access ended on its ack cycle
  logic [14:0] exp_rdata    = '0;

  // Wait (bounded) until the DUT reports busy after a posedge.
  task automatic wait_accept(output int edges, output int early_ack);
    edges     = 0;
    early_ack = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ack) early_ack++;
    end while (!busy && edges < 6);
  endtask

  task automatic do_txn(input logic t_we, input logic [11:0] t_addr, input logic [14:0] t_wdata,
                        input int gap, input bit scramble, input bit hold);
    int          edges, viol, lat, tp0, tp0_nowe, tp_cyc, we_cyc, exp_edges, exp_lat;
    logic [11:0] a_cap;
    logic [14:0] d_cap, wd_at_tp;
    logic        prev_we;
    bit          fixed, zero, good_wr;
    fixed   = (t_addr[11:10] != 2'b00);
    zero    = (t_addr == ZERO_ADDR);
    good_wr = t_we && !fixed && !zero;
    exp_lat = !t_we ? 3 : (good_wr ? 4 : 2);
    if (gap > 0) begin
      req = 1'b0;
      repeat (gap) @(negedge clk);
      pending_done = 1'b0;
    end
    exp_edges = pending_done ? 2 : 1;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    wait_accept(edges, viol);
    check("accept_edges", edges, exp_edges);
    tp0 = tp_edges; tp0_nowe = tp_no_we;
    tp_cyc = 0; we_cyc = 0; lat = 0; prev_we = 1'b0; wd_at_tp = '0;
    a_cap = mem_addr; d_cap = mem_wdata;
    check("mem_addr", a_cap, t_addr);
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (scramble) begin
        we = 1'($urandom); addr = 12'($urandom); wdata = 15'($urandom);
      end
      if (!busy) viol++;
      if (mem_tp) begin
        tp_cyc++;
        wd_at_tp = mem_wdata;
        if (!prev_we) viol++;
      end
      if (mem_we) we_cyc++;
      if (mem_addr !== a_cap || mem_wdata !== d_cap) viol++;
      prev_we = mem_we;
      if (ack) begin
        lat = c;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("err", err, t_we && fixed);
    if (!t_we) exp_rdata = zero ? 15'd0 : ref_mem[t_addr];
    check("rdata", rdata, exp_rdata);
    check("tp_edges", tp_edges - tp0, good_wr);
    check("tp_cycles", tp_cyc, good_wr);
    check("tp_without_we", tp_no_we - tp0_nowe, 0);
    check("we_cycles", we_cyc, good_wr ? 2 : 0);
    check("protocol", viol, 0);
    if (good_wr) begin
      ref_mem[t_addr] = edit_model(t_addr, t_wdata);
      check("wdata_at_tp", wd_at_tp, ref_mem[t_addr]);
    end
    check("mem_cell", mem[t_addr], ref_mem[t_addr]);
    if (!hold) req = 1'b0;
    pending_done = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          edges, early, tp0;
    logic [14:0] old;
    logic [11:0] a;

    for (int i = 0; i < 4096; i++) mem[i] = 15'($urandom);
    mem[12'o0100]       = 15'o12345;
    mem[ZERO_ADDR]      = 15'o00777;
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {ack, busy, err, mem_we, mem_tp, rdata, mem_addr, mem_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed accesses.
    do_txn(1'b0, 12'o0100, 15'd0, 1, 1'b0, 1'b0);
    do_txn(1'b1, 12'o0020, 15'o00001, 1, 1'b0, 1'b0);
    do_txn(1'b1, 12'o0021, 15'o40002, 1, 1'b0, 1'b0);
    do_txn(1'b1, 12'o0022, 15'o40001, 1, 1'b0, 1'b0);
    do_txn(1'b1, 12'o0023, 15'o37600, 1, 1'b0, 1'b0);
    do_txn(1'b0, 12'o0020, 15'd0, 1, 1'b0, 1'b0);
    do_txn(1'b1, 12'o2400, 15'o11111, 1, 1'b0, 1'b0);
    do_txn(1'b0, 12'o0100, 15'd0, 1, 1'b0, 1'b0);
    do_txn(1'b1, ZERO_ADDR, 15'o22222, 1, 1'b0, 1'b0);
    do_txn(1'b0, ZERO_ADDR, 15'd0, 1, 1'b0, 1'b0);
    do_txn(1'b1, 12'o1777, 15'o70707, 1, 1'b0, 1'b0);
    do_txn(1'b0, 12'o1777, 15'd0, 1, 1'b0, 1'b0);
    do_txn(1'b0, 12'o2000, 15'd0, 1, 1'b0, 1'b0);

    // Request held through DONE with inputs changing mid-access.
    do_txn(1'b1, 12'o0040, 15'o13572, 1, 1'b1, 1'b1);
    do_txn(1'b0, 12'o0040, 15'd0, 0, 1'b1, 1'b1);
    do_txn(1'b1, 12'o3000, 15'o1, 0, 1'b1, 1'b0);

    // Reset during EDIT of a write to 12'o0050.
    req = 1'b0;
    @(negedge clk);
    old   = mem[12'o0050];
    req   = 1'b1; we = 1'b1; addr = 12'o0050; wdata = ~old;
    wait_accept(edges, early);
    check("rst_txn_accept", edges, 1);
    @(negedge clk);
    check("rst_in_edit_we", mem_we, 1'b1);
    tp0   = tp_edges;
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {ack, busy, err, mem_we, mem_tp, rdata, mem_addr, mem_wdata}, 64'd0);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_tp", tp_edges - tp0, 0);
    check("rst_mem_kept", mem[12'o0050], old);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_idle_busy", busy, 1'b0);
    exp_rdata    = '0;
    pending_done = 1'b0;
    do_txn(1'b0, 12'o0050, 15'd0, 1, 1'b0, 1'b0);

    // Randomized accesses.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       a = EDIT_BASE + 12'($urandom_range(0, 3));
        1:       a = ZERO_ADDR;
        2:       a = 12'o1777;
        3:       a = 12'o2000 + 12'($urandom_range(0, 2047));
        4:       a = 12'($urandom);
        default: a = 12'o0040 + 12'($urandom_range(0, 7));
      endcase
      do_txn(1'($urandom), a, 15'($urandom), int'($urandom_range(0, 2)),
             1'($urandom), 1'($urandom));
    end

    req = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
